// File: rtl/fir_pkg.sv
// Shared widths, state encoding and sizing helper for the time-multiplexed FIR path.
package fir_pkg;

  localparam int DATA_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mac_state_t;

  // Accumulator width: one full product plus enough headroom for summing every tap.
  function automatic int acc_w(input int taps);
    return PROD_W + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_tdm_mac_ctrl_if.sv
// Sample-in / result-out handshakes plus the coefficient write port of the FIR controller.
interface fir_tdm_mac_ctrl_if
  import fir_pkg::*;
#(
  parameter int TAPS = 4
);

  localparam int ACC_W = acc_w(TAPS);
  localparam int AW    = $clog2(TAPS);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  dout;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [DATA_W-1:0] coef_data;

  modport master (
    output in_valid, din, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, dout
  );

endinterface

// File: rtl/fir_tdm_mac_ctrl_broun_multi.sv
// Unsigned 8x8 array multiplier shared by all FIR taps; purely combinational.
module broun_multi
  import fir_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  // Sum one shifted partial-product row per multiplier bit, as in the array structure.
  always_comb begin
    logic [PROD_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < DATA_W; i++) begin
      sum = sum + (PROD_W'(a & {DATA_W{b[i]}}) << i);
    end
    p = sum;
  end

endmodule

// File: rtl/fir_tdm_mac_ctrl.sv
// Time-multiplexed FIR controller: one shared multiplier walks the taps of each
// accepted sample, then the registered result is offered on a valid/ready port.
module fir_tdm_mac_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS = 4
)(
  input  logic               clk,
  input  logic               rst,
  fir_tdm_mac_ctrl_if.slave  bus,
  output logic               busy
);

  localparam int ACC_W = acc_w(TAPS);
  localparam int AW    = $clog2(TAPS);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_MAC   = MAC;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_OUT   = OUT;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] x [TAPS];
  logic [DATA_W-1:0] h [TAPS];
  logic [AW-1:0]     k;
  logic [PROD_W-1:0] prod_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  dout_q;
  logic [DATA_W-1:0] mult_a;
  logic [DATA_W-1:0] mult_b;
  logic [PROD_W-1:0] mult_p;
  logic              last_tap;
  logic              coef_ok;

  assign mult_a   = x[k];
  assign mult_b   = h[k];
  assign last_tap = (k == AW'(TAPS - 1));

  // Coefficients change only while idle, and addresses past the last tap are dropped.
  assign coef_ok  = (state == S_IDLE) && bus.coef_we && (int'(bus.coef_addr) < TAPS);

  broun_multi u_mult (
    .a (mult_a),
    .b (mult_b),
    .p (mult_p)
  );

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_OUT);
  assign bus.dout      = dout_q;
  assign busy          = (state == S_MAC) || (state == S_DRAIN);

  // Sequence: accept a sample, one tap per cycle, one drain cycle, then hold until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid)  state_nxt = S_MAC;
      S_MAC:   if (last_tap)      state_nxt = S_DRAIN;
      S_DRAIN:                    state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready) state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: the product is registered before it reaches the accumulator,
  // so the drain cycle adds the last product that is still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      prod_q <= '0;
      acc    <= '0;
      dout_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (coef_ok) begin
        h[bus.coef_addr] <= bus.coef_data;
      end
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x[0] <= bus.din;
            for (int i = 1; i < TAPS; i++) begin
              x[i] <= x[i-1];
            end
            acc    <= '0;
            prod_q <= '0;
            k      <= '0;
          end
        end
        S_MAC: begin
          prod_q <= mult_p;
          acc    <= acc + ACC_W'(prod_q);
          k      <= last_tap ? '0 : k + AW'(1);
        end
        S_DRAIN: begin
          dout_q <= acc + ACC_W'(prod_q);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/fir_tdm_mac_ctrl.md
# fir_tdm_mac_ctrl

Time-multiplexed FIR controller for the 8-bit unsigned filter path. It shares one 8x8 Braun array multiplier (`broun_multi`) across all taps. For each accepted sample it sequences the tap products one per cycle into a registered product stage and an accumulator, then presents the filter output over a valid/ready handshake. It sits between the sample source and the downstream filter consumer, and owns the coefficient registers.

## Interface
- `TAPS`, default 4: number of filter taps; must be at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  sample available.
- `in_ready`  out  1  controller can accept a sample.
- `din`  in  8  unsigned input sample.
- `out_valid`  out  1  `dout` holds a completed filter result.
- `out_ready`  in  1  consumer accepts `dout`.
- `dout`  out  ACC_W  unsigned filter output; ACC_W = 16 + $clog2(TAPS).
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  $clog2(TAPS)  tap index.
- `coef_data`  in  8  unsigned coefficient.
- `busy`  out  1  high in MAC and DRAIN states.

## Operation
- Storage:
  - delay line `x[0..TAPS-1]`, 8 bits each;
  - coefficients `h[0..TAPS-1]`, 8 bits each;
  - tap index `k`;
  - `prod_q`, 16 bits;
  - `acc`, ACC_W bits.
- Arithmetic:
  - all arithmetic is unsigned;
  - `prod_q` is zero-extended into `acc`;
  - no saturation is needed, since the maximum TAPS*255*255 fits ACC_W.
- FSM states:
  - IDLE: `in_ready`=1.
  - MAC: `busy`=1; `k` runs 0..TAPS-1.
  - DRAIN: `busy`=1; final accumulate.
  - OUT: `out_valid`=1.
- IDLE, when `in_valid`=1:
  - sample accepted;
  - `x[0]`<=`din`, `x[i]`<=`x[i-1]`;
  - `acc`<=0, `prod_q`<=0, `k`<=0;
  - next state MAC.
- MAC, every cycle:
  - `prod_q`<=`x[k]`*`h[k]`, computed by the shared multiplier;
  - `acc`<=`acc`+`prod_q`;
  - `k`<=`k`+1;
  - at `k`=TAPS-1, next state DRAIN.
- DRAIN:
  - `dout`<=`acc`+`prod_q`;
  - next state OUT.
- OUT:
  - `out_valid`=1 while waiting for the consumer;
  - on `out_ready`=1, next state IDLE.
- `dout` and `out_valid`:
  - `dout` is registered and held stable until the transfer;
  - `out_valid` never drops without `out_ready`.
- Coefficient writes:
  - honoured only in IDLE;
  - `coef_we` in MAC, DRAIN or OUT is ignored (dropped, not queued).
- Simultaneous coefficient write and sample acceptance in IDLE: both take effect, and the new coefficient is used for that sample.
- `coef_addr` ≥ TAPS (non-power-of-2 TAPS only): write ignored.
- `in_valid` outside IDLE: no effect; the sample is not consumed.

## Timing
- Reset (while `rst` high and on the next edge):
  - state IDLE;
  - all `x`, `h`, `acc`, `prod_q`, `dout` cleared to 0;
  - `k`=0.
- Output values after reset:
  - `in_ready`=1;
  - `out_valid`=0;
  - `busy`=0;
  - `dout`=0.
- Latency: `out_valid` rises TAPS+1 cycles after the accepting edge (5 for TAPS=4).
- Throughput: with `out_ready` tied high, one sample per TAPS+3 cycles.
- `out_ready` held low: OUT is held indefinitely; `in_ready` stays 0.
- Reset mid-MAC or mid-OUT: the result is discarded, the delay line is cleared, and no `out_valid` pulse is produced.
- The multiplier path is combinational from `x[k]`/`h[k]` and ends at `prod_q`. There is no direct multiplier-to-accumulator path in one cycle.

## Structure
- Package `fir_pkg`:
  - `DATA_W`=8, `PROD_W`=16;
  - function `acc_w(TAPS)`;
  - `typedef enum {IDLE, MAC, DRAIN, OUT}` as `mac_state_t`.
- Sub-module: a single instance of `broun_multi`. Its inputs are driven by `x[k]`/`h[k]` muxes; its 16-bit output feeds `prod_q`.
- The remainder is one always_ff block plus next-state logic. Target size: 150-250 RTL lines.

## Test plan
- Impulse response:
  - stimulus: `h`={1,2,3,4}; samples 1,0,0,0,0;
  - required: `dout` sequence 1,2,3,4,0.
- Step response:
  - stimulus: `h`={1,2,3,4}; samples 10,20,30;
  - required: `dout` 10, 40, 100.
- Worst case:
  - stimulus: all `h`=255; four samples of 255;
  - required: fourth `dout`=260100, with no overflow in 18 bits.
- Backpressure:
  - stimulus: `out_ready` held 0 for 3 cycles in OUT;
  - required: `dout` stable, `out_valid`=1, `in_ready`=0; transfer on the 4th cycle, then `in_ready`=1.
- Coefficient gating:
  - stimulus: write `h[0]`=9 during MAC;
  - required: write ignored; next result uses the old `h[0]`. The same write in IDLE alongside `in_valid` takes effect for that sample.
- Reset mid-operation:
  - stimulus: assert `rst` in DRAIN;
  - required: next cycle `out_valid`=0, `in_ready`=1, `dout`=0; a following sample 5 with `h`=0 gives `dout`=0.
